// File: rtl/clk_event_generator.sv
// Regenerates a clock phase-aligned to recovered rising edges, with edge and preempt events.
// Optional signed phase error reporting is built when CLK_EVENT_GEN_PHASE_ERROR_EN is defined.
package common_p;
  typedef struct packed {
    logic clk;
    logic rst;
  } clk_dom_s;
endpackage

module clk_event_generator #(
  parameter int unsigned RATE_W       = 16,
  parameter int unsigned PREEMPT_LEAD = 2,
  parameter int unsigned ERR_W        = 8
) (
  input  common_p::clk_dom_s sys_dom_i,
  input  logic               gen_en_i,
  input  logic               clear_state_i,
  input  logic               resync_en_i,
  input  logic               high_locked_in_i,
  input  logic               low_locked_in_i,
  input  logic [RATE_W-1:0]  high_rate_i,
  input  logic [RATE_W-1:0]  low_rate_i,
  input  logic               actual_rise_i,
  output logic               gen_active_o,
  output logic               expected_clk_o,
  output logic               expected_rise_o,
  output logic               expected_fall_o,
  output logic               preempt_rise_o,
  output logic               preempt_fall_o,
  output logic [ERR_W-1:0]   phase_error_o,
  output logic               phase_error_valid_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_HIGH, ST_LOW} state_e;

  localparam logic [RATE_W-1:0] LEAD_M1 = RATE_W'(PREEMPT_LEAD - 1);

  logic clk;
  logic rst;
  assign clk = sys_dom_i.clk;
  assign rst = sys_dom_i.rst;

  state_e            state_q, state_d;
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic [RATE_W-1:0] high_sh_q, high_sh_d;
  logic [RATE_W-1:0] low_sh_q, low_sh_d;
  logic              active_q, active_d;
  logic              clk_q, clk_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              pre_rise_q, pre_rise_d;
  logic              pre_fall_q, pre_fall_d;

  logic locked;
  logic running;
  logic resync;

  assign locked  = gen_en_i && high_locked_in_i && low_locked_in_i;
  assign running = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign resync  = resync_en_i && actual_rise_i && running;

  function automatic logic [RATE_W-1:0] eff_rate(input logic [RATE_W-1:0] r);
    return (r == '0) ? RATE_W'(1) : r;
  endfunction

  // Preempt position saturates to the first cycle of a phase shorter than the lead.
  function automatic logic [RATE_W-1:0] lead_pos(input logic [RATE_W-1:0] shadow);
    logic [RATE_W-1:0] last;
    last = shadow - RATE_W'(1);
    return (LEAD_M1 < last) ? LEAD_M1 : last;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    high_sh_d = high_sh_q;
    low_sh_d  = low_sh_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (clear_state_i || !locked) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      high_sh_d = '0;
      low_sh_d  = '0;
    end else if (resync) begin
      state_d   = ST_HIGH;
      high_sh_d = eff_rate(high_rate_i);
      cnt_d     = high_sh_d - RATE_W'(1);
      rise_d    = (state_q == ST_LOW);
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (actual_rise_i) begin
            state_d   = ST_HIGH;
            high_sh_d = eff_rate(high_rate_i);
            cnt_d     = high_sh_d - RATE_W'(1);
            rise_d    = 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt_q == '0) begin
            state_d  = ST_LOW;
            low_sh_d = eff_rate(low_rate_i);
            cnt_d    = low_sh_d - RATE_W'(1);
            fall_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - RATE_W'(1);
          end
        end
        ST_LOW: begin
          if (cnt_q == '0) begin
            state_d   = ST_HIGH;
            high_sh_d = eff_rate(high_rate_i);
            cnt_d     = high_sh_d - RATE_W'(1);
            rise_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - RATE_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    active_d   = (state_d == ST_HIGH) || (state_d == ST_LOW);
    clk_d      = (state_d == ST_HIGH);
    pre_fall_d = (state_d == ST_HIGH) && !resync && (cnt_d == lead_pos(high_sh_d));
    pre_rise_d = (state_d == ST_LOW) && !resync && (cnt_d == lead_pos(low_sh_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      high_sh_q  <= '0;
      low_sh_q   <= '0;
      active_q   <= 1'b0;
      clk_q      <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      pre_rise_q <= 1'b0;
      pre_fall_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_sh_q  <= high_sh_d;
      low_sh_q   <= low_sh_d;
      active_q   <= active_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      pre_rise_q <= pre_rise_d;
      pre_fall_q <= pre_fall_d;
    end
  end

  assign gen_active_o    = active_q;
  assign expected_clk_o  = clk_q;
  assign expected_rise_o = rise_q;
  assign expected_fall_o = fall_q;
  assign preempt_rise_o  = pre_rise_q;
  assign preempt_fall_o  = pre_fall_q;

`ifdef CLK_EVENT_GEN_PHASE_ERROR_EN
  localparam int unsigned EW = ((RATE_W > ERR_W) ? RATE_W : ERR_W) + 2;
  localparam logic signed [EW-1:0] ERR_MAX = EW'((64'd1 << (ERR_W - 1)) - 64'd1);

  logic signed [EW-1:0] err_raw;
  logic signed [EW-1:0] err_sat;
  logic [ERR_W-1:0]     perr_q, perr_d;
  logic                 perr_v_q, perr_v_d;

  // Early rises (in LOW) come out negative, late rises (in HIGH) positive.
  always_comb begin
    if (state_q == ST_HIGH) begin
      err_raw = $signed(EW'(high_sh_q)) - $signed(EW'(cnt_q));
    end else begin
      err_raw = -$signed(EW'(cnt_q));
    end
    if (err_raw > ERR_MAX) begin
      err_sat = ERR_MAX;
    end else if (err_raw < ~ERR_MAX) begin
      err_sat = ~ERR_MAX;
    end else begin
      err_sat = err_raw;
    end
    perr_d   = perr_q;
    perr_v_d = 1'b0;
    if (clear_state_i || !locked) begin
      perr_d = '0;
    end else if (actual_rise_i && running) begin
      perr_d   = err_sat[ERR_W-1:0];
      perr_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q   <= '0;
      perr_v_q <= 1'b0;
    end else begin
      perr_q   <= perr_d;
      perr_v_q <= perr_v_d;
    end
  end

  assign phase_error_o       = perr_q;
  assign phase_error_valid_o = perr_v_q;
`else
  assign phase_error_o       = '0;
  assign phase_error_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_clk_event_generator.sv
// Randomized bench for clk_event_generator against a phase-position model, plus literal pins.
module tb_clk_event_generator;
  localparam int RATE_W = 16;
  localparam int LEAD   = 2;
  localparam int ERR_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  common_p::clk_dom_s sys_dom;
  assign sys_dom.clk = clk;
  assign sys_dom.rst = rst;

  logic              gen_en = 1'b0, clear = 1'b0, resync_en = 1'b0;
  logic              hlock = 1'b0, llock = 1'b0, arise = 1'b0;
  logic [RATE_W-1:0] high_rate = '0, low_rate = '0;
  logic              active, eclk, erise, efall, prise, pfall, pev;
  logic [ERR_W-1:0]  perr;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // model: mode 0 idle, 1 armed, 2 running; position counted from phase start
  int m_mode = 0, m_high = 0, m_len = 1, m_pos = 0;
  int e_active = 0, e_clk = 0, e_rise = 0, e_fall = 0, e_prer = 0, e_pref = 0;
  int e_perr = 0, e_pv = 0;

  logic [1:6] lit_clk  = 6'b111001;
  logic [1:6] lit_rise = 6'b100001;
  logic [1:6] lit_fall = 6'b000100;
  logic [1:6] lit_pref = 6'b010000;
  logic [1:6] lit_prer = 6'b000100;

  clk_event_generator #(.RATE_W(RATE_W), .PREEMPT_LEAD(LEAD), .ERR_W(ERR_W)) dut (
    .sys_dom_i          (sys_dom),
    .gen_en_i           (gen_en),
    .clear_state_i      (clear),
    .resync_en_i        (resync_en),
    .high_locked_in_i   (hlock),
    .low_locked_in_i    (llock),
    .high_rate_i        (high_rate),
    .low_rate_i         (low_rate),
    .actual_rise_i      (arise),
    .gen_active_o       (active),
    .expected_clk_o     (eclk),
    .expected_rise_o    (erise),
    .expected_fall_o    (efall),
    .preempt_rise_o     (prise),
    .preempt_fall_o     (pfall),
    .phase_error_o      (perr),
    .phase_error_valid_o(pev)
  );

  always #5 clk = ~clk;

  function automatic int eff(input int r);
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int sat(input int v);
    int hi, lo;
    hi = (1 << (ERR_W - 1)) - 1;
    lo = -(1 << (ERR_W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int pick_rate();
    if ($urandom_range(0, 19) == 0) return int'($urandom_range(130, 300));
    return int'($urandom_range(0, 6));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cycle, act, exp);
    end
  endtask

  task automatic pin(input string name, input int dut_v, input int mdl_v, input int exp);
    chk({name, "_dut"}, dut_v, exp);
    chk({name, "_model"}, mdl_v, exp);
  endtask

  task automatic model_step();
    int sup;
    sup    = 0;
    e_rise = 0;
    e_fall = 0;
    e_pv   = 0;
    if (rst || clear || !(gen_en && hlock && llock)) begin
      m_mode = 0;
      e_perr = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (arise) begin
        m_mode = 2; m_high = 1; m_len = eff(int'(high_rate)); m_pos = 0; e_rise = 1;
      end
    end else begin
`ifdef CLK_EVENT_GEN_PHASE_ERROR_EN
      if (arise) begin
        e_pv   = 1;
        e_perr = sat(m_high != 0 ? m_pos + 1 : m_pos + 1 - m_len);
      end
`endif
      if (arise && resync_en) begin
        e_rise = (m_high == 0) ? 1 : 0;
        m_high = 1; m_len = eff(int'(high_rate)); m_pos = 0; sup = 1;
      end else begin
        m_pos++;
        if (m_pos == m_len) begin
          m_high = (m_high == 0) ? 1 : 0;
          m_len  = eff(m_high != 0 ? int'(high_rate) : int'(low_rate));
          m_pos  = 0;
          if (m_high != 0) e_rise = 1;
          else e_fall = 1;
        end
      end
    end
    e_active = (m_mode == 2) ? 1 : 0;
    e_clk    = (m_mode == 2 && m_high != 0) ? 1 : 0;
    e_pref   = (m_mode == 2 && m_high != 0 && sup == 0 &&
                m_pos == ((m_len - LEAD > 0) ? m_len - LEAD : 0)) ? 1 : 0;
    e_prer   = (m_mode == 2 && m_high == 0 && sup == 0 &&
                m_pos == ((m_len - LEAD > 0) ? m_len - LEAD : 0)) ? 1 : 0;
  endtask

  task automatic compare_all();
    chk("gen_active", int'(active), e_active);
    chk("expected_clk", int'(eclk), e_clk);
    chk("expected_rise", int'(erise), e_rise);
    chk("expected_fall", int'(efall), e_fall);
    chk("preempt_rise", int'(prise), e_prer);
    chk("preempt_fall", int'(pfall), e_pref);
    chk("phase_error", int'(perr), e_perr & ((1 << ERR_W) - 1));
    chk("phase_error_valid", int'(pev), e_pv);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cycle++;
    compare_all();
  endtask

  task automatic pin_all_zero(input string tag);
    pin({tag, "_active"}, int'(active), e_active, 0);
    pin({tag, "_clk"}, int'(eclk), e_clk, 0);
    pin({tag, "_rise"}, int'(erise), e_rise, 0);
    pin({tag, "_fall"}, int'(efall), e_fall, 0);
    pin({tag, "_prer"}, int'(prise), e_prer, 0);
    pin({tag, "_pref"}, int'(pfall), e_pref, 0);
    pin({tag, "_perr"}, int'(perr), e_perr, 0);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    pin_all_zero("reset");

    rst = 1'b0; gen_en = 1'b1; hlock = 1'b1; llock = 1'b1;
    high_rate = 16'd3; low_rate = 16'd2; resync_en = 1'b0; arise = 1'b0;
    tick();
    arise = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      arise = 1'b0;
      pin("lock_clk", int'(eclk), e_clk, int'(lit_clk[i]));
      pin("lock_rise", int'(erise), e_rise, int'(lit_rise[i]));
      pin("lock_fall", int'(efall), e_fall, int'(lit_fall[i]));
      pin("lock_pref", int'(pfall), e_pref, int'(lit_pref[i]));
      pin("lock_prer", int'(prise), e_prer, int'(lit_prer[i]));
    end

    low_rate = 16'd3; resync_en = 1'b1;
    for (int i = 7; i <= 10; i++) tick();
    pin("early_prer", int'(prise), e_prer, 1);
    arise = 1'b1;
    tick();
    arise = 1'b0;
    pin("early_rise", int'(erise), e_rise, 1);
    pin("early_clk", int'(eclk), e_clk, 1);
`ifdef CLK_EVENT_GEN_PHASE_ERROR_EN
    pin("early_perr", int'(perr), e_perr & 8'hFF, 8'hFF);
    pin("early_pev", int'(pev), e_pv, 1);
`else
    pin("early_pev", int'(pev), e_pv, 0);
`endif
    tick();
    llock = 1'b0;
    tick();
    pin_all_zero("lockloss");
    llock = 1'b1;

    for (int n = 0; n < 4000; n++) begin
      rst    = ($urandom_range(0, 499) == 0);
      clear  = ($urandom_range(0, 149) == 0);
      gen_en = ($urandom_range(0, 199) != 0);
      hlock  = ($urandom_range(0, 299) != 0);
      llock  = ($urandom_range(0, 299) != 0);
      arise  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 63) == 0) resync_en = ~resync_en;
      if ($urandom_range(0, 15) == 0) high_rate = RATE_W'(pick_rate());
      if ($urandom_range(0, 15) == 0) low_rate = RATE_W'(pick_rate());
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
